unified_mem_arbiter: RTL and testbench

Shares the CPU's single-ported unified memory between instruction fetch and the load/store path. Arbitrates the two requesters, issues one memory transaction at a time over a req/gnt/rvalid handshake, and routes the response to the owner. Load/store has priority; a starvation guard forces a fetch grant after a bounded run of data grants. Sits between the fetch/memory stages and the memory wrapper.

---
 rtl/unified_mem_arbiter.sv | 122 ++++++++++++
 tb/tb_unified_mem_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-ported memory between fetch and load/store.
// Load/store wins ties; a starvation guard forces a fetch grant after a run of data grants.
module unified_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic                dm_gnt,
  output logic                dm_rvalid,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RSP
  } state_t;

  localparam logic [3:0] LIM = 4'(STARVE_LIM);

  state_t     state;
  logic       owner_dm;
  logic [3:0] starve_cnt;
  logic       sel_dm;
  logic       sel_if;
  logic       starved;

  // Fetch is starved only if it is actually waiting at the limit.
  assign starved = if_req && (starve_cnt == LIM);

  always_comb begin
    sel_dm = 1'b0;
    sel_if = 1'b0;
    if (state == IDLE) begin
      sel_dm = dm_req && !starved;
      sel_if = if_req && !sel_dm;
    end
  end

  assign if_gnt    = sel_if;
  assign dm_gnt    = sel_dm;
  assign if_rvalid = (state == RSP) && mem_rvalid && !owner_dm;
  assign dm_rvalid = (state == RSP) && mem_rvalid && owner_dm;
  assign if_rdata  = mem_rdata;
  assign dm_rdata  = mem_rdata;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner_dm   <= 1'b0;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (sel_dm) begin
            owner_dm  <= 1'b1;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_be    <= dm_be;
            state     <= REQ;
            if (!if_req)
              starve_cnt <= '0;
            else if (starve_cnt != LIM)
              starve_cnt <= starve_cnt + 4'd1;
          end else if (sel_if) begin
            owner_dm   <= 1'b0;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
            mem_be     <= '1;
            state      <= REQ;
            starve_cnt <= '0;
          end else if (!if_req) begin
            starve_cnt <= '0;
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= RSP;
          end
        end
        RSP: begin
          if (mem_rvalid)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: directed fetch/load/store
// traffic against a small memory responder, responses checked by a monitor.
module tb_unified_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy;

  logic        auto_mem;
  logic        a_gnt, a_rvalid, m_gnt, m_rvalid;
  logic [31:0] a_rdata, m_rdata;
  int          gnt_delay, rsp_delay;

  assign mem_gnt    = auto_mem ? a_gnt    : m_gnt;
  assign mem_rvalid = auto_mem ? a_rvalid : m_rvalid;
  assign mem_rdata  = auto_mem ? a_rdata  : m_rdata;

  unified_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_LIM(4)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_be(dm_be), .dm_gnt(dm_gnt),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          dm;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  string       glog = "";
  logic [31:0] mem_arr [logic [31:0]];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_str(input string name, input string act,
                         input string exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %s expected %s", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got timeout expected completion", name);
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : 32'h0;
  endfunction

  // memory responder with programmable grant / response delays
  initial begin : responder
    int          gcnt, rcnt;
    bit          pend, pwe;
    logic [31:0] paddr, tmp;
    gcnt = 0; rcnt = 0; pend = 0; pwe = 0; paddr = 0;
    a_gnt = 0; a_rvalid = 0; a_rdata = 0;
    forever begin
      @(posedge clk); #1;
      a_gnt = 0;
      a_rvalid = 0;
      if (!auto_mem) begin
        pend = 0; gcnt = 0; rcnt = 0;
      end else if (pend) begin
        if (rcnt == rsp_delay) begin
          a_rvalid = 1;
          a_rdata = pwe ? 32'h0 : rd(paddr);
          pend = 0;
          rcnt = 0;
        end else rcnt++;
      end else if (mem_req) begin
        if (gcnt == gnt_delay) begin
          a_gnt = 1; gcnt = 0; pend = 1;
          paddr = mem_addr; pwe = mem_we;
          if (mem_we) begin
            tmp = rd(mem_addr);
            for (int b = 0; b < 4; b++)
              if (mem_be[b]) tmp[8*b +: 8] = mem_wdata[8*b +: 8];
            mem_arr[mem_addr] = tmp;
          end
        end else gcnt++;
      end else gcnt = 0;
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (if_gnt && dm_gnt) glog = {glog, "B"};
      else if (dm_gnt) glog = {glog, "D"};
      else if (if_gnt) glog = {glog, "I"};
      if (if_rvalid || dm_rvalid) begin
        chk("rsp_onehot", 64'(if_rvalid && dm_rvalid), 64'd0);
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 64'(dm_rvalid), 64'(2));
        end else begin
          e = sb.pop_front();
          chk("rsp_owner", 64'(dm_rvalid), 64'(e.dm));
          chk("rsp_data", e.dm ? dm_rdata : if_rdata, e.data);
        end
      end
    end
  end

  task automatic fetch(input logic [31:0] a, input logic [31:0] exp);
    int n = 0;
    if_req = 1; if_addr = a;
    forever begin
      @(negedge clk);
      if (if_gnt) break;
      if (++n > 100) break;
    end
    if (n > 100) fail("fetch_gnt");
    else sb.push_back('{0, exp});
    @(posedge clk); #1;
    if_req = 0;
  endtask

  task automatic dm_access(input bit we, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] be,
                           input logic [31:0] exp);
    int n = 0;
    dm_req = 1; dm_we = we; dm_addr = a; dm_wdata = wd; dm_be = be;
    forever begin
      @(negedge clk);
      if (dm_gnt) break;
      if (++n > 100) break;
    end
    if (n > 100) fail("dm_gnt");
    else sb.push_back('{1, exp});
    @(posedge clk); #1;
    dm_req = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail("wait_idle");
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1; auto_mem = 1; gnt_delay = 0; rsp_delay = 0;
    m_gnt = 0; m_rvalid = 0; m_rdata = 0;
    if_req = 0; if_addr = 0;
    dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0; dm_be = 0;
    mem_arr[32'h100]  = 32'h00500093;
    mem_arr[32'h104]  = 32'h00A00113;
    mem_arr[32'h10C]  = 32'h00F00213;
    mem_arr[32'h110]  = 32'h01000193;
    mem_arr[32'h114]  = 32'h01400293;
    mem_arr[32'h40]   = 32'hCAFEF00D;
    mem_arr[32'h2000] = 32'h11223344;
    for (int i = 0; i < 6; i++)
      mem_arr[32'h300 + 32'(4*i)] = 32'h30000000 + 32'(i);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_fields", {mem_we, mem_be, mem_addr}, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_gnt_rvalid", {if_gnt, dm_gnt, if_rvalid, dm_rvalid}, 0);
    @(posedge clk); #1;
    rst = 0;

    // single fetch, minimum latency
    if_req = 1; if_addr = 32'h100;
    @(negedge clk);
    chk("t1_if_gnt", if_gnt, 1);
    chk("t1_dm_gnt", dm_gnt, 0);
    sb.push_back('{0, 32'h00500093});
    @(posedge clk); #1;
    if_req = 0;
    @(negedge clk);
    chk("t1_c1_req", {mem_req, mem_we, mem_be}, {1'b1, 1'b0, 4'hF});
    chk("t1_c1_addr", mem_addr, 32'h100);
    @(negedge clk);
    chk("t1_c2_rvalid", {if_rvalid, dm_rvalid, mem_req}, 3'b100);
    @(negedge clk);
    chk("t1_c3_busy", busy, 0);
    @(posedge clk); #1;

    // store with delayed memory grant
    gnt_delay = 3;
    dm_req = 1; dm_we = 1; dm_addr = 32'h2000;
    dm_wdata = 32'hDEADBEEF; dm_be = 4'b0011;
    @(negedge clk);
    chk("t2_dm_gnt", {dm_gnt, if_gnt}, 2'b10);
    sb.push_back('{1, 32'h0});
    @(posedge clk); #1;
    dm_req = 0; dm_we = 0; dm_addr = 32'hFFFFFFFC;
    dm_wdata = 0; dm_be = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t2_hold_ctl", {mem_req, mem_we, mem_be}, {1'b1, 1'b1, 4'b0011});
      chk("t2_hold_addr", mem_addr, 32'h2000);
      chk("t2_hold_wdata", mem_wdata, 32'hDEADBEEF);
    end
    @(posedge clk); #1;
    wait_idle();
    gnt_delay = 0;
    dm_access(0, 32'h2000, 0, 0, 32'h1122BEEF);
    wait_idle();

    // simultaneous requests: data first
    glog = "";
    fork
      fetch(32'h104, 32'h00A00113);
      dm_access(0, 32'h40, 0, 0, 32'hCAFEF00D);
    join
    wait_idle();
    chk_str("t3_order", glog, "DI");

    // starvation guard
    glog = "";
    fork
      begin
        for (int i = 0; i < 6; i++)
          dm_access(0, 32'h300 + 32'(4*i), 0, 0, 32'h30000000 + 32'(i));
      end
      begin
        fetch(32'h110, 32'h01000193);
        fetch(32'h114, 32'h01400293);
      end
    join
    wait_idle();
    chk_str("t4_order", glog, "DDDDIDDI");

    // reset while waiting for the response
    rsp_delay = 2;
    if_req = 1; if_addr = 32'h108;
    @(negedge clk);
    chk("t5_if_gnt", if_gnt, 1);
    @(posedge clk); #1;
    if_req = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_in_rsp", {busy, mem_req}, 2'b10);
    rst = 1;
    #1;
    chk("t5_rst_now", {busy, mem_req, if_rvalid, dm_rvalid}, 0);
    chk("t5_rst_fields", {mem_be, mem_addr}, 0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_late_rvalid", {if_rvalid, dm_rvalid, busy}, 0);
    rsp_delay = 0;
    @(posedge clk); #1;
    fetch(32'h10C, 32'h00F00213);
    wait_idle();

    // spurious handshakes
    auto_mem = 0;
    m_rvalid = 1; m_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    chk("t6_idle_rvalid", {if_rvalid, dm_rvalid, busy}, 0);
    @(posedge clk); #1;
    m_rvalid = 0;
    @(negedge clk);
    chk("t6_idle_stay", {busy, mem_req}, 0);
    @(posedge clk); #1;
    if_req = 1; if_addr = 32'h100;
    @(negedge clk);
    chk("t6_if_gnt", if_gnt, 1);
    sb.push_back('{0, 32'h12345678});
    @(posedge clk); #1;
    if_req = 0; m_gnt = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_rsp_gnt", {busy, mem_req, if_rvalid}, 3'b100);
    @(posedge clk); #1;
    m_gnt = 0; m_rvalid = 1; m_rdata = 32'h12345678;
    @(negedge clk);
    chk("t6_rvalid", {if_rvalid, dm_rvalid}, 2'b10);
    @(posedge clk); #1;
    m_rvalid = 0;
    @(negedge clk);
    chk("t6_back_idle", busy, 0);
    @(posedge clk); #1;
    auto_mem = 1;

    wait_idle();
    chk("sb_empty", 64'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
